// File: rtl/mux_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared mode constants and parameter legality check for the
//               registered N-to-1 round-robin multiplexer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  // Channel count must be 2..16 and every channel index must fit in sel_w bits.
  function automatic bit sel_w_ok(input int n, input int sel_w);
    return (n >= 2) && (n <= 16) && ((1 << sel_w) >= n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_arb.sv
// ============================================================================
// Module      : mux_rr_arb
// Description : Combinational round-robin winner search starting at rr_ptr.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [2*N-1:0] w_doubled;
  logic [N-1:0]   w_rotated;
  logic [SEL_W:0] w_sum;

  always_comb begin
    w_doubled = {valid, valid};
    // Bit k of the rotated vector is channel (rr_ptr + k) mod N.
    w_rotated = N'(w_doubled >> rr_ptr);
    found     = 1'b0;
    w_sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        found = 1'b1;
        w_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      end
    end
    if (w_sum >= N_EXT) begin
      w_sum = w_sum - N_EXT;
    end
    winner = w_sum[SEL_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_reg.sv
// ============================================================================
// Module      : mux_rr_reg
// Description : Registered N-to-1 data mux with valid/ready handshakes, fixed
//               or round-robin selection and a one-entry output stage.
//               Optional parity output enabled by macro MUX_RR_PARITY_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [N-1:0]       valid_in,
  output logic [N-1:0]       ready_in,
  output logic [WIDTH-1:0]   data_out,
  output logic [SEL_W-1:0]   chan_out,
  output logic               valid_out,
  input  logic               ready_out
`ifdef MUX_RR_PARITY_EN
  ,
  output logic               parity_out
`endif
);

  localparam int              SEL_SPAN = 1 << SEL_W;
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N - 1);

  if (!sel_w_ok(N, SEL_W)) begin : g_bad_params
    $error("mux_rr_reg: illegal N/SEL_W combination");
  end

  logic [WIDTH-1:0] data_q,   data_d;
  logic [SEL_W-1:0] chan_q,   chan_d;
  logic             valid_q,  valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_RR_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [SEL_SPAN-1:0] w_valid_pad;
  logic                w_can_load;
  logic                w_sel_in_range;
  logic                w_fixed_hit;
  logic                w_grant_hit;
  logic                w_load;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [SEL_W-1:0]    w_rr_winner;
  logic                w_rr_found;
  logic [WIDTH-1:0]    w_mux_data;

  mux_rr_arb #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .valid  (valid_in),
    .rr_ptr (rr_ptr_q),
    .winner (w_rr_winner),
    .found  (w_rr_found)
  );

  always_comb begin
    // Padding lets sel index the valid vector safely even when sel >= N.
    w_valid_pad    = SEL_SPAN'(valid_in);
    w_can_load     = !valid_q || ready_out;
    w_sel_in_range = ({1'b0, sel} < N_EXT);
    w_fixed_hit    = w_sel_in_range && w_valid_pad[sel];
    if (mode == MUX_MODE_RR) begin
      w_grant_idx = w_rr_winner;
      w_grant_hit = w_rr_found;
    end else begin
      w_grant_idx = sel;
      w_grant_hit = w_fixed_hit;
    end
    w_load     = !reset && w_can_load && w_grant_hit;
    ready_in   = '0;
    w_mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        ready_in[i] = w_load;
        w_mux_data  = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MUX_RR_PARITY_EN
    parity_d = parity_q;
`endif
    if (w_load) begin
      data_d  = w_mux_data;
      chan_d  = w_grant_idx;
      valid_d = 1'b1;
`ifdef MUX_RR_PARITY_EN
      parity_d = ^w_mux_data;
`endif
      if (mode == MUX_MODE_RR) begin
        rr_ptr_d = (w_grant_idx == LAST_CH) ? '0 : w_grant_idx + SEL_W'(1);
      end
    end else if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
`ifdef MUX_RR_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      data_q   <= data_d;
      chan_q   <= chan_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MUX_RR_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign chan_out  = chan_q;
  assign valid_out = valid_q;
`ifdef MUX_RR_PARITY_EN
  assign parity_out = parity_q;
`endif

endmodule

`default_nettype wire
